// File: rtl/audio_sample_packer.sv
// audio_sample_packer
// Packs 24-bit stereo PCM frames from the capture stage into 16-bit words
// and queues them in an output FIFO. The frame strobe arrives from the BCK
// domain and is synchronised here before it is used.
//
// Optional feature: define AUDIO_SEQ_WORD_EN to append a fourth word,
// {4'hA, seq[11:0]}, to every frame. seq counts every capture event,
// including dropped frames, so the consumer can detect gaps.
//
// Frames are written whole or not at all. A frame is dropped, and the
// sticky overflow flag set, when the FIFO lacks room for every word of it,
// or when a capture arrives while the previous frame is still being written.

module audio_sample_packer #(
  parameter int FIFO_DEPTH = 16   // power of two, 8 or more
) (
  input  logic                          clk_40MHz,
  input  logic                          reset,
  input  logic [23:0]                   left_in,
  input  logic [23:0]                   right_in,
  input  logic                          sample_ready_in,
  output logic [15:0]                   data_out,
  output logic                          data_valid,
  input  logic                          data_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          overflow_clear
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

`ifdef AUDIO_SEQ_WORD_EN
  localparam int FRAME_WORDS = 4;
`else
  localparam int FRAME_WORDS = 3;
`endif

  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] WORDS_L = LVL_W'(FRAME_WORDS);

  // ------------------------------------------------------------------
  // Strobe synchroniser, edge detect and arming
  // ------------------------------------------------------------------
  logic       sync1_reg;
  logic       sync2_reg;
  logic       sync_prev_reg;
  logic       capture_reg;
  logic       armed_reg;
  logic [1:0] prime_cnt_reg;
  logic       strobe_rise;

  // The synchroniser flops reset to 0, so their first two outputs after
  // reset are not real samples of the strobe. prime_cnt_reg waits until
  // sync2_reg carries a true sample before a low level may arm capture;
  // otherwise a strobe held high through reset would look like a new edge.
  assign strobe_rise = armed_reg & sync2_reg & ~sync_prev_reg;

  // Two-flop synchroniser, edge history, arming and registered capture event
  always_ff @(posedge clk_40MHz) begin
    if (reset) begin
      sync1_reg     <= 1'b0;
      sync2_reg     <= 1'b0;
      sync_prev_reg <= 1'b0;
      capture_reg   <= 1'b0;
      armed_reg     <= 1'b0;
      prime_cnt_reg <= 2'd0;
    end else begin
      sync1_reg     <= sample_ready_in;
      sync2_reg     <= sync1_reg;
      sync_prev_reg <= sync2_reg;
      capture_reg   <= strobe_rise;
      if (prime_cnt_reg != 2'd2) begin
        prime_cnt_reg <= prime_cnt_reg + 2'd1;
      end
      if ((prime_cnt_reg == 2'd2) && !sync2_reg) begin
        armed_reg <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // Frame writer FSM
  // ------------------------------------------------------------------
`ifdef AUDIO_SEQ_WORD_EN
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR0  = 3'd1,
    ST_WR1  = 3'd2,
    ST_WR2  = 3'd3,
    ST_WR3  = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR0  = 2'd1,
    ST_WR1  = 2'd2,
    ST_WR2  = 2'd3
  } state_t;
`endif

  state_t            state_reg;
  state_t            state_next;
  logic [LVL_W-1:0]  level_reg;
  logic [LVL_W-1:0]  free_words;
  logic              frame_fits;
  logic              frame_accept;
  logic              frame_drop;
  logic              fifo_push;
  logic [15:0]       push_word;
  logic              fifo_pop;
  logic [23:0]       hold_left_reg;
  logic [23:0]       hold_right_reg;

  // Room is judged on the level seen in the capture cycle. Pops can only
  // add room while the frame is written, so a frame that fits here never
  // overruns the FIFO.
  assign free_words   = DEPTH_L - level_reg;
  assign frame_fits   = (free_words >= WORDS_L);
  assign frame_accept = capture_reg && (state_reg == ST_IDLE) && frame_fits;
  assign frame_drop   = capture_reg && !frame_accept;

  // State register
  always_ff @(posedge clk_40MHz) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: one cycle per word, then back to IDLE
  always_comb begin
    state_next = ST_IDLE;
    case (state_reg)
      ST_IDLE: state_next = frame_accept ? ST_WR0 : ST_IDLE;
      ST_WR0:  state_next = ST_WR1;
      ST_WR1:  state_next = ST_WR2;
`ifdef AUDIO_SEQ_WORD_EN
      ST_WR2:  state_next = ST_WR3;
      ST_WR3:  state_next = ST_IDLE;
`else
      ST_WR2:  state_next = ST_IDLE;
`endif
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef AUDIO_SEQ_WORD_EN
  logic [11:0] seq_reg;
  logic [11:0] hold_seq_reg;

  // Sequence counter advances on every capture event, accepted or not,
  // and the accepted frame snapshots the value it was captured with
  always_ff @(posedge clk_40MHz) begin
    if (reset) begin
      seq_reg      <= 12'd0;
      hold_seq_reg <= 12'd0;
    end else begin
      if (capture_reg) begin
        seq_reg <= seq_reg + 12'd1;
      end
      if (frame_accept) begin
        hold_seq_reg <= seq_reg;
      end
    end
  end
`endif

  // Output decode: exactly one FIFO write in each WRn state
  always_comb begin
    fifo_push = 1'b0;
    push_word = 16'h0000;
    case (state_reg)
      ST_WR0: begin
        fifo_push = 1'b1;
        push_word = hold_left_reg[23:8];
      end
      ST_WR1: begin
        fifo_push = 1'b1;
        push_word = {hold_left_reg[7:0], hold_right_reg[23:16]};
      end
      ST_WR2: begin
        fifo_push = 1'b1;
        push_word = hold_right_reg[15:0];
      end
`ifdef AUDIO_SEQ_WORD_EN
      ST_WR3: begin
        fifo_push = 1'b1;
        push_word = {4'hA, hold_seq_reg};
      end
`endif
      default: begin
        fifo_push = 1'b0;
        push_word = 16'h0000;
      end
    endcase
  end

  // Holding registers load only for an accepted frame, so a capture that
  // is dropped mid-frame cannot disturb the words still being written
  always_ff @(posedge clk_40MHz) begin
    if (reset) begin
      hold_left_reg  <= 24'd0;
      hold_right_reg <= 24'd0;
    end else if (frame_accept) begin
      hold_left_reg  <= left_in;
      hold_right_reg <= right_in;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk_40MHz) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (frame_drop) begin
      overflow <= 1'b1;
    end else if (overflow_clear) begin
      overflow <= 1'b0;
    end
  end

  // ------------------------------------------------------------------
  // Output FIFO
  // ------------------------------------------------------------------
  logic [15:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;

  assign data_valid = (level_reg != '0);
  assign fifo_pop   = data_valid && data_ready;
  assign fifo_level = level_reg;

  // Head word is read straight from storage so it is present in the same
  // cycle data_valid rises; forced to zero while empty so nothing stale
  // is visible after reset
  assign data_out = data_valid ? mem[rd_ptr_reg] : 16'h0000;

  // Storage write; contents need no reset because level gates visibility
  always_ff @(posedge clk_40MHz) begin
    if (fifo_push) begin
      mem[wr_ptr_reg] <= push_word;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; level tracks
  // simultaneous push and pop as no change
  always_ff @(posedge clk_40MHz) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({fifo_push, fifo_pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: doc/audio_sample_packer.md
AUDIO_SAMPLE_PACKER -- requirements
Module: audio_sample_packer

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, word capacity of output FIFO; SHALL be a power of two, minimum 8.
REQ-002 clk_40MHz  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 left_in  input  24  left sample from PCM1802 capture stage; stable for at least 8 clk_40MHz cycles after sample_ready_in rises.
REQ-005 right_in  input  24  right sample, same stability guarantee as left_in.
REQ-006 sample_ready_in  input  1  asynchronous frame strobe from BCK domain, high for at least 2 clk_40MHz cycles.
REQ-007 data_out  output  16  FIFO head word.
REQ-008 data_valid  output  1  high when the FIFO is non-empty.
REQ-009 data_ready  input  1  consumer accept; a pop occurs when data_valid and data_ready are both high.
REQ-010 fifo_level  output  $clog2(FIFO_DEPTH)+1  current word count.
REQ-011 overflow  output  1  sticky dropped-frame flag.
REQ-012 overflow_clear  input  1  clears overflow.

Function
REQ-013 sample_ready_in SHALL pass through a 2-flop synchronizer; a capture event SHALL be the synchronized rising edge, registered once (3-cycle latency from the input edge).
REQ-014 After reset, no capture SHALL occur until the synchronized strobe has been observed low at least once (arming).
REQ-015 On a capture event, left_in and right_in SHALL be latched into holding registers in the same cycle.
REQ-016 Frame word count W = 3 (4 with AUDIO_SEQ_WORD_EN); word order: W0=L[23:8], W1={L[7:0],R[23:16]}, W2=R[15:0].
REQ-017 FSM states: IDLE, WR0, WR1, WR2 (plus WR3 with the macro); exactly one FIFO write per state, one cycle per state, then return to IDLE.
REQ-018 IDLE->WR0 SHALL occur only if the capture event sees FIFO_DEPTH-fifo_level >= W; otherwise the whole frame SHALL be dropped, overflow set, and FSM stays IDLE (no partial frames, ever).
REQ-019 A capture event arriving while not in IDLE SHALL drop that frame and set overflow; the in-progress frame SHALL complete unaffected.
REQ-020 Push and pop in the same cycle SHALL both take effect; fifo_level unchanged.
REQ-021 Pop when empty is impossible (data_valid low); FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 data_out SHALL be the head word combinationally from FIFO storage and SHALL remain stable while data_valid is high and data_ready is low.
REQ-023 overflow_clear SHALL clear overflow next cycle; a concurrent new overflow event SHALL win (overflow stays 1).

Reset
REQ-024 Reset SHALL set: FSM IDLE, FIFO empty, fifo_level 0, data_valid 0, data_out 0, overflow 0, synchronizer flops 0, armed 0, holding registers 0, sequence counter 0.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame and all FIFO contents; no word of it SHALL appear after reset release.

Configuration
REQ-026 Macro AUDIO_SEQ_WORD_EN defined: W=4; WR3 writes {4'hA, seq[11:0]}; seq SHALL increment on every capture event (accepted or dropped), wrapping 0xFFF->0x000.
REQ-027 Macro undefined: W=3, no WR3 state, no sequence counter logic.

Verification
REQ-028 L=0x123456, R=0xABCDEF, data_ready=1 -> words 0x1234, 0x56AB, 0xCDEF (macro: then 0xA000), data_valid deasserted afterwards.
REQ-029 data_ready=0, FIFO_DEPTH=16, macro off, 6 frames -> first 5 accepted (level 15), 6th dropped, overflow=1, level stays 15.
REQ-030 Strobe held high through reset release -> no capture; next low-then-high strobe -> exactly one frame written.
REQ-031 Reset asserted in WR1 -> next cycle fifo_level=0, data_valid=0, overflow=0.
REQ-032 Macro on, 4097 frames with data_ready=1 -> seq words 0xA000..0xAFFF then 0xA000; overflow_clear and drop in same cycle -> overflow remains 1.
